iobus_timer_responder: RTL and testbench

//  Memory-mapped timer/interrupt peripheral on the OTTER IOBUS; the responder
//  to the pipelined CPU's IOBUS_ADDR/IOBUS_OUT/IOBUS_WR/IOBUS_IN transactions.
//  It decodes CPU stores and loads to its register window and runs a prescaled
//  up-counter with one-shot or periodic expiry. It drives the CPU INTR input.

---
 rtl/iobus_timer_responder.sv | 127 ++++++++++++
 tb/tb_iobus_timer_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/iobus_timer_responder.sv
// Memory-mapped timer/interrupt responder on the OTTER IOBUS.
// Prescaled up-counter with one-shot or periodic expiry, registered read port, level INTR.
module iobus_timer_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
  parameter int          PRESCALE_W = 16
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        INTR
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                state_q, state_d;
  logic                  periodic_q, periodic_d;
  logic                  ie_q, ie_d;
  logic                  pend_q, pend_d;
  logic [31:0]           period_q, period_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;

  logic        hit, wr, tick, expire;
  logic [2:0]  slot;
  logic [31:0] rd_val;
  logic        unused_addr_lsb;

  assign hit             = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
  assign slot            = IOBUS_ADDR[4:2];
  assign wr              = IOBUS_WR & hit;
  assign unused_addr_lsb = ^IOBUS_ADDR[1:0];
  assign tick            = (state_q == RUN) && (pre_cnt_q == prescale_q);
  assign expire          = tick && (count_q == period_q);

  // CTRL.EN reflects the live run state, so a one-shot expiry reads back EN=0.
  always_comb begin
    rd_val = '0;
    case (slot)
      3'd0: rd_val = {29'b0, ie_q, periodic_q, state_q == RUN};
      3'd1: rd_val = period_q;
      3'd2: rd_val = count_q;
      3'd3: rd_val = {31'b0, pend_q};
      3'd4: rd_val = 32'(prescale_q);
      default: rd_val = '0;
    endcase
    rdata_d = hit ? rd_val : '0;
  end

  always_comb begin
    state_d    = state_q;
    periodic_d = periodic_q;
    ie_d       = ie_q;
    pend_d     = pend_q;
    period_d   = period_q;
    count_d    = count_q;
    pre_cnt_d  = pre_cnt_q;
    prescale_d = prescale_q;

    if (state_q == RUN) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
      if (expire) begin
        pend_d = 1'b1;
        if (periodic_q) count_d = '0;
        else            state_d = DONE;
      end else if (tick) begin
        count_d = count_q + 32'd1;
      end
    end

    // Bus writes are applied last so they override the counter update.
    if (wr) begin
      case (slot)
        3'd0: begin
          periodic_d = IOBUS_OUT[1];
          ie_d       = IOBUS_OUT[2];
          if (IOBUS_OUT[0]) begin
            if (state_q != RUN) begin
              state_d   = RUN;
              pre_cnt_d = '0;
              if (state_q == DONE) count_d = '0;
            end
          end else if (state_q == RUN) begin
            state_d = IDLE;
          end
        end
        3'd1: period_d = IOBUS_OUT;
        3'd2: count_d  = IOBUS_OUT;
        3'd3: if (IOBUS_OUT[0] && !expire) pend_d = 1'b0;
        3'd4: prescale_d = IOBUS_OUT[PRESCALE_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      periodic_q <= 1'b0;
      ie_q       <= 1'b0;
      pend_q     <= 1'b0;
      period_q   <= 32'hFFFF_FFFF;
      count_q    <= '0;
      rdata_q    <= '0;
      pre_cnt_q  <= '0;
      prescale_q <= '0;
    end else begin
      state_q    <= state_d;
      periodic_q <= periodic_d;
      ie_q       <= ie_d;
      pend_q     <= pend_d;
      period_q   <= period_d;
      count_q    <= count_d;
      rdata_q    <= rdata_d;
      pre_cnt_q  <= pre_cnt_d;
      prescale_q <= prescale_d;
    end
  end

  assign IOBUS_IN = rdata_q;
  assign INTR     = pend_q & ie_q;

endmodule

// File: tb/tb_iobus_timer_responder.sv
// Bench for iobus_timer_responder: directed scenarios plus random bus traffic
// compared each cycle against a cycle-level behavioural model.
module tb_iobus_timer_responder;

  localparam logic [31:0] BASE = 32'h1100_0100;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] IOBUS_ADDR = '0;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic        INTR;

  int checks = 0;
  int errors = 0;

  iobus_timer_responder #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .INTR(INTR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: timer behaviour in plain terms
  bit          m_running, m_finished, m_per, m_ie, m_pend;
  logic [31:0] m_period, m_count, m_rd;
  int unsigned m_pre, m_prescale;

  task automatic model_reset();
    m_running = 0; m_finished = 0; m_per = 0; m_ie = 0; m_pend = 0;
    m_period = 32'hFFFF_FFFF; m_count = 0; m_rd = 0; m_pre = 0; m_prescale = 0;
  endtask

  function automatic logic [31:0] m_read(input int slot);
    case (slot)
      0: return {29'b0, m_ie, m_per, m_running};
      1: return m_period;
      2: return m_count;
      3: return {31'b0, m_pend};
      4: return m_prescale;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input bit wr, input logic [31:0] a, input logic [31:0] d);
    bit hit = (a[31:5] == BASE[31:5]);
    int slot = int'(a[4:2]);
    bit was_run = m_running, was_done = m_finished, expire = 0;
    logic [31:0] nrd = hit ? m_read(slot) : 32'd0;
    if (was_run) begin
      if (m_pre == m_prescale) begin
        m_pre = 0;
        if (m_count == m_period) begin
          expire = 1; m_pend = 1;
          if (m_per) m_count = 0;
          else begin m_running = 0; m_finished = 1; end
        end else m_count = m_count + 1;
      end else m_pre++;
    end
    if (wr && hit) begin
      case (slot)
        0: begin
          m_per = d[1]; m_ie = d[2];
          if (d[0]) begin
            if (!was_run) begin
              m_running = 1; m_finished = 0; m_pre = 0;
              if (was_done) m_count = 0;
            end
          end else if (was_run) begin
            m_running = 0; m_finished = 0;
          end
        end
        1: m_period = d;
        2: m_count = d;
        3: if (d[0] && !expire) m_pend = 0;
        4: m_prescale = d[15:0];
        default: ;
      endcase
    end
    m_rd = nrd;
  endtask

  // One bus cycle: drive, clock, step the model, compare.
  task automatic cyc(input bit wr, input logic [31:0] a, input logic [31:0] d);
    IOBUS_WR = wr; IOBUS_ADDR = a; IOBUS_OUT = d;
    @(posedge CLK);
    model_step(wr, a, d);
    #1;
    chk("model_iobus_in", IOBUS_IN, m_rd);
    chk("model_intr", {31'b0, INTR}, {31'b0, m_pend & m_ie});
  endtask

  task automatic hard_reset();
    IOBUS_WR = 0;
    #2 RESET_N = 0;
    model_reset();
    @(posedge CLK);
    #1 RESET_N = 1;
  endtask

  task automatic wait_intr(output int k);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc(0, 32'h0, 32'h0);
      if (INTR) begin k = i; break; end
    end
  endtask

  int k;

  initial begin
    model_reset();
    #3;
    chk("reset_iobus_in", IOBUS_IN, 32'h0);
    chk("reset_intr", {31'b0, INTR}, 32'h0);
    #9 RESET_N = 1;

    // One-shot
    cyc(1, BASE + 32'h10, 0);
    cyc(1, BASE + 32'h04, 4);
    cyc(1, BASE + 32'h00, 5);
    wait_intr(k);
    chk("oneshot_latency", k, 5);
    cyc(0, BASE + 32'h00, 0); chk("oneshot_ctrl", IOBUS_IN, 32'h4);
    cyc(0, BASE + 32'h08, 0); chk("oneshot_count", IOBUS_IN, 32'h4);
    cyc(1, BASE + 32'h0C, 1); chk("oneshot_w1c", {31'b0, INTR}, 0);

    // Periodic
    hard_reset();
    cyc(1, BASE + 32'h10, 2);
    cyc(1, BASE + 32'h04, 1);
    cyc(1, BASE + 32'h00, 7);
    wait_intr(k); chk("periodic_first", k, 6);
    cyc(1, BASE + 32'h0C, 1); chk("periodic_clr", {31'b0, INTR}, 0);
    wait_intr(k); chk("periodic_second", k, 5);
    cyc(1, BASE + 32'h0C, 1);
    for (int i = 0; i < 4; i++) cyc(0, 32'h0, 0);
    chk("periodic_pre_expiry", {31'b0, INTR}, 0);
    cyc(1, BASE + 32'h0C, 1); chk("periodic_set_wins", {31'b0, INTR}, 1);

    // Asynchronous reset mid-run
    cyc(0, BASE + 32'h04, 0); chk("pre_reset_rd", IOBUS_IN, 32'h1);
    #2 RESET_N = 0;
    #1;
    chk("async_rst_in", IOBUS_IN, 0);
    chk("async_rst_intr", {31'b0, INTR}, 0);
    model_reset();
    @(posedge CLK); #1 RESET_N = 1;
    cyc(0, BASE + 32'h08, 0); chk("rst_count", IOBUS_IN, 0);
    cyc(0, BASE + 32'h04, 0); chk("rst_period", IOBUS_IN, 32'hFFFF_FFFF);
    cyc(0, BASE + 32'h00, 0); chk("rst_ctrl", IOBUS_IN, 0);

    // Readback and decode
    cyc(1, BASE + 32'h04, 32'h1234_5678);
    cyc(0, BASE + 32'h04, 0); chk("readback_period", IOBUS_IN, 32'h1234_5678);
    cyc(1, BASE + 32'h04, 32'hAAAA_5555); chk("rd_during_wr_old", IOBUS_IN, 32'h1234_5678);
    cyc(0, BASE + 32'h14, 0); chk("rd_unused_slot", IOBUS_IN, 0);
    cyc(0, BASE + 32'h20, 0); chk("rd_outside", IOBUS_IN, 0);
    cyc(1, BASE + 32'h24, 32'hDEAD_BEEF);
    cyc(0, BASE + 32'h04, 0); chk("outside_wr_ignored", IOBUS_IN, 32'hAAAA_5555);

    // Preload and 32-bit wrap
    hard_reset();
    cyc(1, BASE + 32'h00, 0);
    cyc(1, BASE + 32'h08, 32'hFFFF_FFFE);
    cyc(1, BASE + 32'h04, 1);
    cyc(1, BASE + 32'h10, 0);
    cyc(1, BASE + 32'h00, 5);
    wait_intr(k); chk("wrap_latency", k, 4);

    // COUNT write colliding with a tick, via a misaligned address
    hard_reset();
    cyc(1, BASE + 32'h10, 0);
    cyc(1, BASE + 32'h04, 100);
    cyc(1, BASE + 32'h00, 1);
    cyc(0, 32'h0, 0);
    cyc(1, BASE + 32'h0B, 32'h50);
    cyc(0, BASE + 32'h08, 0); chk("collision_count", IOBUS_IN, 32'h50);

    // Random traffic
    hard_reset();
    for (int n = 0; n < 1500; n++) begin
      int s = $urandom_range(0, 7);
      logic [31:0] a = BASE + 32'(s * 4) + 32'($urandom_range(0, 3));
      logic [31:0] d;
      bit w = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) a = $urandom;
      case (s)
        0: d = $urandom_range(0, 7);
        1: d = $urandom_range(0, 6);
        2: d = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                         : 32'($urandom_range(0, 5));
        4: d = $urandom_range(0, 3);
        default: d = $urandom;
      endcase
      cyc(w, a, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
